reg_desloc_universal: RTL
=========================

// Module: reg_desloc_universal
// PURPOSE
//   Parametrised universal shift register: the generalised successor of the
//   fixed 4-stage serial-in shift chain. WIDTH-bit register with hold,
//   shift right, shift left and parallel load, plus a synchronous clear and a
//   shift counter flagging when every loaded bit has been shifted out.
//   Used as a serializer/deserializer stage between datapath blocks and
//   serial links.
// PARAMETERS
//   WIDTH      8      register width in bits, >= 2
//   RESET_VAL  '0     value loaded into Q on reset and on clr (WIDTH bits)
// PORTS
//   clk      in   1          rising-edge clock
//   nReset   in   1          asynchronous reset, active low
//   clr      in   1          synchronous clear: Q <= RESET_VAL, cnt <= 0
//   en       in   1          1 = execute mode; 0 = hold everything
//   mode     in   2          00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r    in   1          serial in, enters Q[WIDTH-1] on shift right
//   sin_l    in   1          serial in, enters Q[0] on shift left
//   D        in   WIDTH      parallel load data
//   Q        out  WIDTH      register contents (registered, no comb path)
//   sout_r   out  1          = Q[0], bit leaving on next shift right
//   sout_l   out  1          = Q[WIDTH-1], bit leaving on next shift left
//   cnt      out  CW         shifts since last load/clear/reset, CW=$clog2(WIDTH+1)
//   drained  out  1          = (cnt == WIDTH)
// BEHAVIOUR
//   - nReset low (any time, async): Q=RESET_VAL, cnt=0, drained=0; held
//     while low; operation resumes on the first rising clk after release.
//   - Priority per rising edge: clr > (en==0 hold) > mode.
//   - mode 00: Q, cnt unchanged.
//   - mode 01: Q <= {sin_r, Q[WIDTH-1:1]}; cnt <= sat(cnt+1).
//   - mode 10: Q <= {Q[WIDTH-2:0], sin_l}; cnt <= sat(cnt+1).
//   - mode 11: Q <= D; cnt <= 0 (load wins over counting).
//   - sat(): cnt saturates at WIDTH; never wraps; further shifts keep
//     shifting Q, cnt stays WIDTH, drained stays 1.
//   - Direction changes mid-stream still count; cnt is shift count, not
//     net displacement.
//   - Latency: one cycle; Q/cnt reflect the operation after the edge it is
//     sampled on. sout_r/sout_l/drained are combinational from registers.
//   - clr with en=0: clear still happens. clr with mode 11: clear wins, D
//     ignored.
//   - mode/sin/D sampled only at rising clk; no other state.
// TESTING  (WIDTH=8, RESET_VAL=8'h00)
//   1 nReset pulse mid-shift (async, between edges) -> Q=00, cnt=0
//     immediately, drained=0.
//   2 load D=8'hA5, then 8 shift-right with sin_r=0 -> sout_r sequence
//     1,0,1,0,0,1,0,1; Q=00; cnt=8; drained=1 after 8th edge.
//   3 Q=00, 8 shift-left with sin_l=1,1,0,1,0,0,0,1 -> Q=8'hD1; 9th shift
//     -> cnt stays 8.
//   4 load 8'h81, en=0 with mode=01 for 3 cycles -> Q=81, cnt=0; then
//     en=1 shift left once -> Q=8'h02 (sin_l=0), cnt=1.
//   5 load 8'h3C, shift right 2 (cnt=2), then clr together with mode=11,
//     D=FF -> Q=00, cnt=0.
//   6 load 8'hF0, shift right 3 then left 3 (sin=0) -> Q=8'hF0
//     (0x1E << 3 = 0xF0), cnt=6, drained=0.

Source files
------------

// File: rtl/reg_desloc_universal_if.sv
// Control/data bundle for the universal shift register.
// master = the block driving mode/data, slave = the register itself.
interface reg_desloc_universal_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
);
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             drained;

  modport master (
    output clr, en, mode, sin_r, sin_l, D,
    input  Q, sout_r, sout_l, cnt, drained
  );

  modport slave (
    input  clr, en, mode, sin_r, sin_l, D,
    output Q, sout_r, sout_l, cnt, drained
  );
endinterface

// File: rtl/reg_desloc_universal.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with synchronous clear and a saturating shift counter (drained flag).
// Each bit is an identical cell; neighbours are wired as a ring-free chain
// with the serial inputs feeding the two ends.

// One bit of the register: picks its next value from the upper neighbour
// (shift right), the lower neighbour (shift left) or the load data.
module reg_desloc_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_from_hi,
  input  logic       i_from_lo,
  input  logic       i_d,
  output logic       o_q
);
  logic r_q;

  // clr beats en, en=0 freezes the bit, otherwise mode selects the source
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)     r_q <= RST_BIT;
    else if (i_clr)  r_q <= RST_BIT;
    else if (i_en) begin
      case (i_mode)
        2'b01:   r_q <= i_from_hi;
        2'b10:   r_q <= i_from_lo;
        2'b11:   r_q <= i_d;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;
endmodule

module reg_desloc_universal #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  nReset,
  reg_desloc_universal_if.slave bus
);
  localparam int            CW      = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_hi;   // source for each bit on a right shift
  logic [WIDTH-1:0] w_lo;   // source for each bit on a left shift
  logic [CW-1:0]    r_cnt;

  assign w_hi = {bus.sin_r, w_q[WIDTH-1:1]};
  assign w_lo = {w_q[WIDTH-2:0], bus.sin_l};

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      reg_desloc_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
        .clk       (clk),
        .nReset    (nReset),
        .i_clr     (bus.clr),
        .i_en      (bus.en),
        .i_mode    (bus.mode),
        .i_from_hi (w_hi[i]),
        .i_from_lo (w_lo[i]),
        .i_d       (bus.D[i]),
        .o_q       (w_q[i])
      );
    end
  endgenerate

  // Shift counter: counts shifts in either direction, saturates at WIDTH,
  // cleared by load/clr/reset
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)      r_cnt <= '0;
    else if (bus.clr) r_cnt <= '0;
    else if (bus.en) begin
      case (bus.mode)
        2'b01, 2'b10: if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        2'b11:        r_cnt <= '0;
        default:      r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.Q       = w_q;
  assign bus.sout_r  = w_q[0];
  assign bus.sout_l  = w_q[WIDTH-1];
  assign bus.cnt     = r_cnt;
  assign bus.drained = (r_cnt == CNT_MAX);
endmodule
